// File: rtl/gpu_circle_raster_if.sv
// Request/pixel-stream bundle between the draw pipeline and the circle rasteriser.
// The slave modport is the rasteriser side; master is the requester/framebuffer side.
interface gpu_circle_raster_if #(
  parameter int unsigned X_BITS = 10,
  parameter int unsigned Y_BITS = 9
) ();
  logic              start_i;
  logic [X_BITS-1:0] xc_i;
  logic [Y_BITS-1:0] yc_i;
  logic [X_BITS-1:0] rad_i;
  logic              mode_i;
  logic              abort_i;
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic [X_BITS-1:0] pix_x_o;
  logic [Y_BITS-1:0] pix_y_o;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  start_i, xc_i, yc_i, rad_i, mode_i, abort_i, pix_ready_i,
    output pix_valid_o, pix_x_o, pix_y_o, busy_o, done_o
  );

  modport master (
    output start_i, xc_i, yc_i, rad_i, mode_i, abort_i, pix_ready_i,
    input  pix_valid_o, pix_x_o, pix_y_o, busy_o, done_o
  );
endinterface

// File: rtl/gpu_circle_raster.sv
// Midpoint circle rasteriser: emits screen-clipped pixels (filled spans or outline
// points) over a valid/ready stream, one segment set per midpoint iteration.
module gpu_circle_raster #(
  parameter int unsigned X_BITS   = 10,
  parameter int unsigned Y_BITS   = 9,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input logic                clk,
  input logic                rst,
  gpu_circle_raster_if.slave bus
);

  // Wide signed coordinate space so xc-y or yc+x never wraps before clipping.
  localparam int unsigned CW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;
  localparam int unsigned DW = X_BITS + 3;
  localparam logic signed [CW-1:0] XMax = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] YMax = CW'(SCREEN_H - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StEmit, StStep, StDone} state_e;

  state_e               state_q, state_d;
  logic signed [CW-1:0] xc_q, xc_d, yc_q, yc_d;
  logic signed [CW-1:0] x_q, x_d, y_q, y_d;
  logic signed [DW-1:0] d_q, d_d;
  logic                 mode_q, mode_d;
  logic [2:0]           seg_q, seg_d;
  logic [X_BITS-1:0]    pix_x_q, pix_x_d, span_r_q, span_r_d;
  logic [Y_BITS-1:0]    pix_y_q, pix_y_d;

  logic                 busy;
  logic                 sel, vneg, visible, last_seg;
  logic signed [CW-1:0] hoff, voff, row, xl, xr, span_l, span_r;
  logic signed [CW-1:0] x_n, y_n;
  logic signed [DW-1:0] dx, dy;
  logic                 unused_bits;

  assign busy = (state_q == StSetup) || (state_q == StEmit) || (state_q == StStep);

  // Segment geometry. Filled: seg[0] swaps x/y, seg[1] picks the lower half.
  // Outline: seg[0] mirrors in x, seg[1] swaps x/y, seg[2] mirrors in y.
  always_comb begin
    sel      = mode_q ? seg_q[1] : seg_q[0];
    vneg     = mode_q ? seg_q[2] : seg_q[1];
    hoff     = sel ? y_q : x_q;
    voff     = sel ? x_q : y_q;
    row      = vneg ? (yc_q - voff) : (yc_q + voff);
    xl       = xc_q - hoff;
    xr       = xc_q + hoff;
    if (mode_q) begin
      xl = seg_q[0] ? (xc_q - hoff) : (xc_q + hoff);
      xr = xl;
    end
    span_l   = (xl < 0) ? '0 : xl;
    span_r   = (xr > XMax) ? XMax : xr;
    visible  = (row >= 0) && (row <= YMax) && (span_l <= span_r);
    last_seg = mode_q ? (seg_q == 3'd7) : (seg_q == 3'd3);
  end

  assign unused_bits = ^{span_l[CW-1:X_BITS], span_r[CW-1:X_BITS], row[CW-1:Y_BITS]};

  always_comb begin
    state_d  = state_q;
    xc_d     = xc_q;
    yc_d     = yc_q;
    x_d      = x_q;
    y_d      = y_q;
    d_d      = d_q;
    mode_d   = mode_q;
    seg_d    = seg_q;
    pix_x_d  = pix_x_q;
    pix_y_d  = pix_y_q;
    span_r_d = span_r_q;
    dx       = DW'(x_q);
    dy       = DW'(y_q);
    x_n      = x_q + CW'(1);
    y_n      = (d_q < 0) ? y_q : (y_q - CW'(1));

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          xc_d    = CW'(bus.xc_i);
          yc_d    = CW'(bus.yc_i);
          mode_d  = bus.mode_i;
          x_d     = '0;
          y_d     = CW'(bus.rad_i);
          d_d     = DW'(1) - DW'(bus.rad_i);
          seg_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (visible) begin
          pix_x_d  = span_l[X_BITS-1:0];
          pix_y_d  = row[Y_BITS-1:0];
          span_r_d = span_r[X_BITS-1:0];
          state_d  = StEmit;
        end else if (last_seg) begin
          state_d = StStep;
        end else begin
          seg_d = seg_q + 3'd1;
        end
      end
      StEmit: begin
        if (bus.pix_ready_i) begin
          if (pix_x_q != span_r_q) begin
            pix_x_d = pix_x_q + 1'b1;
          end else if (last_seg) begin
            state_d = StStep;
          end else begin
            seg_d   = seg_q + 3'd1;
            state_d = StSetup;
          end
        end
      end
      StStep: begin
        if (d_q < 0) begin
          d_d = d_q + (dx <<< 1) + DW'(3);
        end else begin
          d_d = d_q + ((dx - dy) <<< 1) + DW'(5);
        end
        x_d = x_n;
        y_d = y_n;
        if (x_n > y_n) begin
          state_d = StDone;
        end else begin
          seg_d   = '0;
          state_d = StSetup;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (busy && bus.abort_i) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      xc_q     <= '0;
      yc_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      mode_q   <= 1'b0;
      seg_q    <= '0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      span_r_q <= '0;
    end else begin
      state_q  <= state_d;
      xc_q     <= xc_d;
      yc_q     <= yc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      d_q      <= d_d;
      mode_q   <= mode_d;
      seg_q    <= seg_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      span_r_q <= span_r_d;
    end
  end

  assign bus.pix_valid_o = (state_q == StEmit);
  assign bus.pix_x_o     = pix_x_q;
  assign bus.pix_y_o     = pix_y_q;
  assign bus.busy_o      = busy;
  assign bus.done_o      = (state_q == StDone);

endmodule

// File: tb/tb_gpu_circle_raster.sv
// Directed bench for gpu_circle_raster: expected pixel streams are queued at start
// and popped by a monitor on every transfer; control cases checked inline.
module tb_gpu_circle_raster;
  localparam int XB = 10;
  localparam int YB = 9;
  localparam int W  = 640;
  localparam int H  = 480;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpu_circle_raster_if #(.X_BITS(XB), .Y_BITS(YB)) bus ();

  gpu_circle_raster #(
    .X_BITS(XB), .Y_BITS(YB), .SCREEN_W(W), .SCREEN_H(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int transfers = 0;
  int done_cnt = 0;
  int stalls = 0;
  bit seen[int];
  int rmin[int];
  int rmax[int];
  bit rand_ready = 1'b0;
  bit stall_chk = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_key;
  int r3_lo[7];
  int r3_hi[7];
  int clip_hi[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] key_of(input logic [XB-1:0] x, input logic [YB-1:0] y);
    return 32'(x) * 1024 + 32'(y);
  endfunction

  // Reference midpoint model, written directly from the span/point tables.
  function automatic void model(input int xc, input int yc, input int r, input bit mode);
    int x = 0;
    int y = r;
    int d = 1 - r;
    int rows[4];
    int hws[4];
    int px[8];
    int py[8];
    while (x <= y) begin
      if (!mode) begin
        rows = '{yc + y, yc + x, yc - y, yc - x};
        hws  = '{x, y, x, y};
        for (int s = 0; s < 4; s++) begin
          int lo = (xc - hws[s] < 0) ? 0 : xc - hws[s];
          int hi = (xc + hws[s] > W - 1) ? W - 1 : xc + hws[s];
          if (rows[s] >= 0 && rows[s] < H)
            for (int c = lo; c <= hi; c++) exp_q.push_back(c * 1024 + rows[s]);
        end
      end else begin
        px = '{xc + x, xc - x, xc + y, xc - y, xc + x, xc - x, xc + y, xc - y};
        py = '{yc + y, yc + y, yc + x, yc + x, yc - y, yc - y, yc - x, yc - x};
        for (int s = 0; s < 8; s++)
          if (px[s] >= 0 && px[s] < W && py[s] >= 0 && py[s] < H)
            exp_q.push_back(px[s] * 1024 + py[s]);
      end
      if (d < 0) d += 2 * x + 3;
      else begin
        d += 2 * (x - y) + 5;
        y--;
      end
      x++;
    end
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  initial forever begin
    logic [31:0] k;
    int px, py;
    @(negedge clk);
    k = key_of(bus.pix_x_o, bus.pix_y_o);
    if (stall_chk && prev_stall) begin
      check("hold_valid", 32'(bus.pix_valid_o), 1);
      check("hold_xy", k, prev_key);
    end
    prev_stall = bus.pix_valid_o && !bus.pix_ready_i;
    if (prev_stall) stalls++;
    prev_key = k;
    if (bus.pix_valid_o && bus.pix_ready_i) begin
      transfers++;
      if (exp_q.size() == 0) check("extra_pixel", k, 32'hffff_ffff);
      else check("pixel", k, exp_q.pop_front());
      px = int'(bus.pix_x_o);
      py = int'(bus.pix_y_o);
      seen[px * 1024 + py] = 1'b1;
      if (!rmin.exists(py) || px < rmin[py]) rmin[py] = px;
      if (!rmax.exists(py) || px > rmax[py]) rmax[py] = px;
    end
    if (bus.done_o) begin
      done_cnt++;
      check("busy_at_done", 32'(bus.busy_o), 0);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.pix_ready_i = 1'($urandom_range(0, 1));
  end

  task automatic clear_run();
    exp_q.delete();
    seen.delete();
    rmin.delete();
    rmax.delete();
    transfers = 0;
    done_cnt  = 0;
    stalls    = 0;
  endtask

  task automatic kick(input int xc, input int yc, input int r, input bit mode);
    @(posedge clk);
    #1;
    bus.xc_i    = XB'(xc);
    bus.yc_i    = YB'(yc);
    bus.rad_i   = XB'(r);
    bus.mode_i  = mode;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", done_cnt, 1);
    repeat (3) @(negedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.pix_valid_o), 0);
    check({tag, "_x"}, 32'(bus.pix_x_o), 0);
    check({tag, "_y"}, 32'(bus.pix_y_o), 0);
    check({tag, "_busy"}, 32'(bus.busy_o), 0);
    check({tag, "_done"}, 32'(bus.done_o), 0);
  endtask

  initial begin
    int n;
    bus.start_i = 1'b0;
    bus.xc_i = '0;
    bus.yc_i = '0;
    bus.rad_i = '0;
    bus.mode_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.pix_ready_i = 1'b1;
    r3_lo = '{99, 98, 97, 97, 97, 98, 99};
    r3_hi = '{101, 102, 103, 103, 103, 102, 101};
    clip_hi = '{3, 3, 2, 1};

    #1 rst = 1'b1;
    #2 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Filled radius 0: four copies of the centre, with the start-up latency checked.
    clear_run();
    repeat (4) exp_q.push_back(10 * 1024 + 10);
    kick(10, 10, 0, 1'b0);
    @(negedge clk);
    check("r0_busy_n1", 32'(bus.busy_o), 1);
    check("r0_setup_novalid", 32'(bus.pix_valid_o), 0);
    @(negedge clk);
    check("r0_first_valid", 32'(bus.pix_valid_o), 1);
    wait_done(50);
    check("r0_transfers", transfers, 4);

    // Outline radius 1, explicit order.
    clear_run();
    exp_q = '{20*1024+21, 20*1024+21, 21*1024+20, 19*1024+20,
              20*1024+19, 20*1024+19, 21*1024+20, 19*1024+20};
    kick(20, 20, 1, 1'b1);
    wait_done(50);
    check("r1_transfers", transfers, 8);

    // Filled radius 3 with ignored start pulses while busy.
    clear_run();
    model(100, 100, 3, 1'b0);
    kick(100, 100, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.xc_i = XB'(5);
      bus.rad_i = XB'(9);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
    end
    wait_done(300);
    check("r3_transfers", transfers, 56);
    check("r3_unique", seen.num(), 37);
    for (int i = 0; i < 7; i++) begin
      check("r3_row_lo", rmin.exists(97 + i) ? rmin[97 + i] : -1, r3_lo[i]);
      check("r3_row_hi", rmax.exists(97 + i) ? rmax[97 + i] : -1, r3_hi[i]);
    end
    check("r3_rows", rmin.num(), 7);

    // Same circle under random backpressure.
    clear_run();
    model(100, 100, 3, 1'b0);
    prev_stall = 1'b0;
    stall_chk = 1'b1;
    rand_ready = 1'b1;
    kick(100, 100, 3, 1'b0);
    wait_done(1000);
    rand_ready = 1'b0;
    stall_chk = 1'b0;
    @(posedge clk);
    #1 bus.pix_ready_i = 1'b1;
    check("bp_transfers", transfers, 56);
    check("bp_unique", seen.num(), 37);
    check("bp_stalls_seen", 32'(stalls > 0), 1);

    // Clipping at the origin corner.
    clear_run();
    model(0, 0, 3, 1'b0);
    kick(0, 0, 3, 1'b0);
    wait_done(300);
    check("clip_unique", seen.num(), 13);
    check("clip_rows", rmin.num(), 4);
    for (int i = 0; i < 4; i++) begin
      check("clip_row_lo", rmin.exists(i) ? rmin[i] : -1, 0);
      check("clip_row_hi", rmax.exists(i) ? rmax[i] : -1, clip_hi[i]);
    end

    // Abort while stalled in EMIT, then a fresh circle.
    clear_run();
    model(100, 100, 3, 1'b0);
    kick(100, 100, 3, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 bus.pix_ready_i = 1'b0;
    n = 0;
    while (!bus.pix_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_emit", 32'(bus.pix_valid_o), 1);
    @(posedge clk);
    #1 bus.abort_i = 1'b1;
    @(posedge clk);
    #1 bus.abort_i = 1'b0;
    check("abort_valid", 32'(bus.pix_valid_o), 0);
    check("abort_busy", 32'(bus.busy_o), 0);
    bus.pix_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    clear_run();
    model(300, 200, 2, 1'b1);
    kick(300, 200, 2, 1'b1);
    wait_done(200);
    check("post_abort_transfers", transfers, 16);

    // Reset in the middle of an outline circle, then a fresh circle.
    clear_run();
    model(200, 100, 5, 1'b1);
    kick(200, 100, 5, 1'b1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    clear_run();
    model(630, 470, 12, 1'b0);
    kick(630, 470, 12, 1'b0);
    wait_done(2000);
    check("post_rst_unique_nonzero", 32'(seen.num() > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
